// File: rtl/mem_pkg.sv
// Shared memory-port definitions: response owner encoding used by the SRAM port
// arbiter and reused by the D-cache / bus bridge.
package mem_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_LS   = 2'd2
    } resp_owner_e;

    localparam int MEM_ADDR_W_DEF = 32;
    localparam int MEM_DATA_W_DEF = 32;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive denied fetch cycles and flags when fetch must be forced
// through; only instantiated when MEM_ARB_STARVE_EN is defined.
module starve_counter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic if_gnt_i,
    output logic starved_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Registered count, so the override never feeds back into this cycle's grant.
    assign starved_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single SRAM port shared by IFU fetch and EXU load/store; LSU has priority,
// optional fetch starvation override under MEM_ARB_STARVE_EN.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W_DEF,
    parameter int DATA_W     = MEM_DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              hold_o,
    input  logic              flush_i,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [DATA_W/8-1:0] sram_be_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i
);

    resp_owner_e resp_q, resp_d;
    logic        flush_q, flush_d;
    logic        starve_win;
    logic        if_gnt, ls_gnt;

`ifdef MEM_ARB_STARVE_EN
    logic starved;

    starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req_i  (if_req_i),
        .if_gnt_i  (if_gnt),
        .starved_o (starved)
    );

    assign starve_win = starved;
`else
    // Strict LSU priority; STARVE_MAX has no effect in this build.
    assign starve_win = 1'b0 & (STARVE_MAX > 0);
`endif

    always_comb begin
        if_gnt       = if_req_i & (~ls_req_i | starve_win);
        ls_gnt       = ls_req_i & ~if_gnt;
        sram_en_o    = if_gnt | ls_gnt;
        sram_we_o    = 1'b0;
        sram_be_o    = '1;
        sram_addr_o  = if_addr_i;
        sram_wdata_o = ls_wdata_i;
        if (ls_gnt) begin
            sram_we_o   = ls_we_i;
            sram_be_o   = ls_be_i;
            sram_addr_o = ls_addr_i;
        end
    end

    always_comb begin
        resp_d  = RESP_NONE;
        flush_d = flush_i;
        if (if_gnt) begin
            resp_d = RESP_IF;
        end else if (ls_gnt && !ls_we_i) begin
            resp_d = RESP_LS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q  <= RESP_NONE;
            flush_q <= 1'b0;
        end else begin
            resp_q  <= resp_d;
            flush_q <= flush_d;
        end
    end

    assign if_gnt_o    = if_gnt;
    assign ls_gnt_o    = ls_gnt;
    assign hold_o      = if_req_i & ~if_gnt;
    assign if_rvalid_o = (resp_q == RESP_IF) & ~flush_q;
    assign ls_rvalid_o = (resp_q == RESP_LS);
    assign if_rdata_o  = sram_rdata_i;
    assign ls_rdata_o  = sram_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif
    localparam int STARVE_MAX = 4;

    typedef struct {
        bit          if_req;
        logic [31:0] if_addr;
        bit          ls_req;
        bit          ls_we;
        logic [3:0]  be;
        logic [31:0] ls_addr;
        logic [31:0] wdata;
        bit          flush;
    } stim_t;

    typedef struct {
        stim_t s;
        bit    e_if_gnt;
        bit    e_ls_gnt;
        bit    e_hold;
        bit    e_we;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o, hold_o;
    logic [31:0] if_rdata_o;
    logic        flush_i = 1'b0;
    logic        ls_req_i = 1'b0, ls_we_i = 1'b0;
    logic [3:0]  ls_be_i = '0;
    logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
    logic        ls_gnt_o, ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        sram_en_o, sram_we_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_addr_o, sram_wdata_o;
    logic [31:0] sram_rdata_i = '0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          exp_if_v = 1'b0;
    bit          exp_ls_v = 1'b0;
    logic [31:0] exp_data = '0;
    int          denied_run = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .hold_o(hold_o),
        .flush_i(flush_i),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk = ~clk;

    // SRAM stand-in: a read returns its address + 0x100 one cycle later.
    always @(posedge clk) begin
        if (sram_en_o && !sram_we_o) sram_rdata_i <= sram_addr_o + 32'h100;
        else                         sram_rdata_i <= $urandom;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive just after posedge, check at negedge, update model.
    task automatic do_cycle(input stim_t s, output bit g_if, output bit g_ls,
                            output bit g_hold, output bit g_we);
        bit starved, e_if, e_ls;
        if_req_i   = s.if_req;  if_addr_i  = s.if_addr;
        ls_req_i   = s.ls_req;  ls_we_i    = s.ls_we;
        ls_be_i    = s.be;      ls_addr_i  = s.ls_addr;
        ls_wdata_i = s.wdata;   flush_i    = s.flush;
        #4;
        chk("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, exp_if_v});
        chk("ls_rvalid", {31'b0, ls_rvalid_o}, {31'b0, exp_ls_v});
        if (exp_if_v) chk("if_rdata", if_rdata_o, exp_data);
        if (exp_ls_v) chk("ls_rdata", ls_rdata_o, exp_data);

        starved = STARVE_EN && (denied_run >= STARVE_MAX);
        e_if = s.if_req && (!s.ls_req || starved);
        e_ls = s.ls_req && !e_if;
        chk("if_gnt", {31'b0, if_gnt_o}, {31'b0, e_if});
        chk("ls_gnt", {31'b0, ls_gnt_o}, {31'b0, e_ls});
        chk("hold", {31'b0, hold_o}, {31'b0, s.if_req && !e_if});
        chk("sram_en", {31'b0, sram_en_o}, {31'b0, e_if || e_ls});
        if (e_if) begin
            chk("sram_addr_if", sram_addr_o, s.if_addr);
            chk("sram_we_if", {31'b0, sram_we_o}, 32'd0);
            chk("sram_be_if", {28'b0, sram_be_o}, 32'hF);
        end
        if (e_ls) begin
            chk("sram_addr_ls", sram_addr_o, s.ls_addr);
            chk("sram_we_ls", {31'b0, sram_we_o}, {31'b0, s.ls_we});
            chk("sram_be_ls", {28'b0, sram_be_o}, {28'b0, s.be});
            if (s.ls_we) chk("sram_wdata", sram_wdata_o, s.wdata);
        end
        g_if = if_gnt_o; g_ls = ls_gnt_o; g_hold = hold_o; g_we = sram_we_o;

        exp_if_v = e_if && !s.flush;
        exp_ls_v = e_ls && !s.ls_we;
        exp_data = (e_if ? s.if_addr : s.ls_addr) + 32'h100;
        if (!s.if_req || e_if) denied_run = 0;
        else denied_run++;
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t mk(bit ifr, logic [31:0] ia, bit lsr, bit we,
                                 logic [3:0] be, logic [31:0] la, logic [31:0] wd, bit fl);
        stim_t s;
        s.if_req = ifr; s.if_addr = ia; s.ls_req = lsr; s.ls_we = we;
        s.be = be; s.ls_addr = la; s.wdata = wd; s.flush = fl;
        return s;
    endfunction

    task automatic model_reset();
        exp_if_v = 1'b0;
        exp_ls_v = 1'b0;
        denied_run = 0;
    endtask

    vec_t  vecs[10];
    stim_t idle;
    bit    gi, gl, gh, gw;

    initial begin
        idle = mk(0, 0, 0, 0, 4'h0, 0, 0, 0);

        // Reset state: rvalids low, grants still combinational.
        if_req_i = 1'b1;
        #3;
        chk("rst_if_rvalid", {31'b0, if_rvalid_o}, 32'd0);
        chk("rst_ls_rvalid", {31'b0, ls_rvalid_o}, 32'd0);
        chk("rst_if_gnt", {31'b0, if_gnt_o}, 32'd1);
        ls_req_i = 1'b1;
        #1;
        chk("rst_ls_wins", {30'b0, ls_gnt_o, if_gnt_o}, 32'd2);
        if_req_i = 1'b0; ls_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        vecs[0] = '{mk(1, 32'h0, 0, 0, 4'h0, 0, 0, 0), 1, 0, 0, 0};
        vecs[1] = '{mk(1, 32'h4, 0, 0, 4'h0, 0, 0, 0), 1, 0, 0, 0};
        vecs[2] = '{mk(1, 32'h8, 0, 0, 4'h0, 0, 0, 0), 1, 0, 0, 0};
        vecs[3] = '{mk(1, 32'hC, 1, 0, 4'hF, 32'h40, 0, 0), 0, 1, 1, 0};
        vecs[4] = '{mk(0, 32'h0, 1, 1, 4'b0011, 32'h80, 32'hDEADBEEF, 0), 0, 1, 0, 1};
        vecs[5] = '{mk(1, 32'h10, 0, 0, 4'h0, 0, 0, 1), 1, 0, 0, 0};
        vecs[6] = '{mk(1, 32'h14, 0, 0, 4'h0, 0, 0, 0), 1, 0, 0, 0};
        vecs[7] = '{idle, 0, 0, 0, 0};
        vecs[8] = '{mk(0, 32'h0, 1, 0, 4'hF, 32'h44, 0, 0), 0, 1, 0, 0};
        vecs[9] = '{mk(1, 32'h18, 1, 1, 4'b1100, 32'h48, 32'h12345678, 0), 0, 1, 1, 1};

        for (int i = 0; i < 10; i++) begin
            do_cycle(vecs[i].s, gi, gl, gh, gw);
            chk($sformatf("vec%0d_gnt", i), {29'b0, gi, gl, gh},
                {29'b0, vecs[i].e_if_gnt, vecs[i].e_ls_gnt, vecs[i].e_hold});
            chk($sformatf("vec%0d_we", i), {31'b0, gw}, {31'b0, vecs[i].e_we});
        end
        do_cycle(idle, gi, gl, gh, gw);

        // Continuous contention: fetch forced through every 5th cycle only with the override.
        for (int i = 0; i < 10; i++) begin
            do_cycle(mk(1, 32'h100 + 32'(i * 4), 1, 0, 4'hF, 32'h200 + 32'(i * 4), 0, 0),
                     gi, gl, gh, gw);
            chk($sformatf("starve_c%0d_if_gnt", i + 1), {31'b0, gi},
                {31'b0, STARVE_EN && (i % 5 == 4)});
        end
        do_cycle(idle, gi, gl, gh, gw);

        // Reset the cycle after a load grant: its response must never appear.
        do_cycle(mk(0, 0, 1, 0, 4'hF, 32'h60, 0, 0), gi, gl, gh, gw);
        rst_n = 1'b0;
        if_req_i = 1'b0; ls_req_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("rst_mid_ls_rvalid", {31'b0, ls_rvalid_o}, 32'd0);
        @(posedge clk);
        #4;
        chk("rst_hold_ls_rvalid", {31'b0, ls_rvalid_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        do_cycle(idle, gi, gl, gh, gw);
        do_cycle(idle, gi, gl, gh, gw);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            s = mk($urandom_range(0, 1), {$urandom_range(0, 255), 2'b00},
                   $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                   {$urandom_range(0, 255), 2'b00}, $urandom, ($urandom_range(0, 3) == 0));
            do_cycle(s, gi, gl, gh, gw);
        end
        do_cycle(idle, gi, gl, gh, gw);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported instruction/data SRAM between the instruction fetch unit (IFU) and the load/store path of the EXU. Requests are granted combinationally in the same cycle. Read responses return one cycle later and are routed to the requester that owned the grant. The block drives the IFU hold so fetch stalls whenever the port goes to a data access. It sits between the IFU/EXU and the SRAM macro in the core top level.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced through (only used with MEM_ARB_STARVE_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_W  fetch address (IFU pc)
- if_gnt_o  out  1  fetch granted this cycle
- if_rvalid_o  out  1  fetch data valid, to IFU instr_valid input
- if_rdata_o  out  DATA_W  fetch data
- hold_o  out  1  IFU hold: if_req_i & ~if_gnt_o
- flush_i  in  1  EXU jump; discards any in-flight fetch response
- ls_req_i  in  1  load/store request
- ls_we_i  in  1  1 = store
- ls_be_i  in  DATA_W/8  byte enables
- ls_addr_i  in  ADDR_W  data address
- ls_wdata_i  in  DATA_W  store data
- ls_gnt_o  out  1  load/store granted this cycle
- ls_rvalid_o  out  1  load data valid
- ls_rdata_o  out  DATA_W  load data
- sram_en_o  out  1  SRAM access enable
- sram_we_o  out  1  SRAM write enable
- sram_be_o  out  DATA_W/8  SRAM byte enables
- sram_addr_o  out  ADDR_W  SRAM address
- sram_wdata_o  out  DATA_W  SRAM write data
- sram_rdata_i  in  DATA_W  SRAM read data, valid one cycle after an enabled read

## Operation
- Grant logic is combinational. By default, LSU has priority over IFU. At most one grant per cycle.
- The SRAM outputs are muxed from the granted requester.
  - IFU grant forces sram_we_o=0 and sram_be_o to all ones.
  - No grant drives sram_en_o=0; the address and data outputs are then don't-care.
- Response owner register resp_q (NONE, IF, LS):
  - Loaded each cycle with IF on an IFU grant.
  - Loaded with LS on an LSU read grant.
  - Loaded with NONE otherwise; LSU writes produce no response.
- Response outputs:
  - if_rvalid_o = (resp_q==IF) & ~flush_q.
  - ls_rvalid_o = (resp_q==LS).
  - Both rdata outputs carry sram_rdata_i unmodified.
- flush_q is a registered flush_i. It suppresses the fetch response issued in the cycle in which flush_i was high.
- flush_i has no effect on grants or on LSU responses.
- Simultaneous if_req_i and ls_req_i: LSU wins and hold_o=1, except when the starvation override is active.

## Timing
- Request and grant are in the same cycle N. The SRAM access is in cycle N. rvalid and rdata appear in cycle N+1, for 1 cycle.
- Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle.
- Reset values:
  - resp_q=NONE, flush_q=0, starvation counter=0.
  - if_rvalid_o=0, ls_rvalid_o=0.
  - Grants follow the request inputs combinationally.
- Reset asserted mid-access: the in-flight response is dropped and no rvalid is issued after reset release.

## Configuration
- MEM_ARB_STARVE_EN defined:
  - A counter of width $clog2(STARVE_MAX+1) increments each cycle with if_req_i & ~if_gnt_o.
  - It clears when IFU is granted or when if_req_i=0.
  - When the counter equals STARVE_MAX, IFU wins over a concurrent LSU request for that cycle, and ls_gnt_o=0.
  - The counter saturates at STARVE_MAX.
- MEM_ARB_STARVE_EN undefined: the counter is absent and the arbitration is strict LSU priority.

## Structure
- Owner encodings NONE=2'd0, IF=2'd1, LS=2'd2 go in a shared package (mem_pkg), reused by the future D-cache/bus bridge.
- Widths come from define.v.
- One natural sub-module: starve_counter, instantiated only under MEM_ARB_STARVE_EN.

## Test plan
- Fetch only, addr 0x0,0x4,0x8 on consecutive cycles, SRAM returns addr+0x100:
  - Expect if_gnt_o=1 every cycle and hold_o=0.
  - Expect if_rvalid_o one cycle later with data 0x100,0x104,0x108.
- Concurrent if_req_i and ls_req_i load at 0x40:
  - Expect ls_gnt_o=1, if_gnt_o=0 and hold_o=1.
  - Expect ls_rvalid_o next cycle with SRAM data.
  - Expect if_rvalid_o=0 in that cycle.
- LSU store, be=4'b0011, wdata 0xDEADBEEF: expect sram_we_o=1, be=0011, and no rvalid on either port next cycle.
- Fetch granted in the same cycle as flush_i=1: expect if_rvalid_o=0 next cycle. The fetch in the following cycle responds normally.
- MEM_ARB_STARVE_EN, STARVE_MAX=4, continuous LSU and IFU requests:
  - Expect an IFU grant on the 5th cycle after 4 denied cycles.
  - Expect the counter to return to 0 afterwards.
  - Without the macro, expect no IFU grant.
- rst_n asserted the cycle after a load grant: expect ls_rvalid_o=0 throughout and after reset release.
